// File: rtl/button_conditioner.sv
// Per-button conditioning: polarity fix, 2-FF synchronizer, debounce FSM, level and edge pulses.
// Define BUTTON_CONDITIONER_LONG_PRESS_EN to add a one-shot long-press pulse on btn_long.
module button_conditioner #(
  parameter int unsigned CLK_FREQ    = 25_000_000,
  parameter int unsigned NUM_BTN     = 4,
  parameter int unsigned DEBOUNCE_US = 10_000,
  parameter bit          ACTIVE_LOW  = 1'b1,
  parameter int unsigned HOLD_MS     = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_long
);

  localparam int unsigned DEBOUNCE_CYCLES = CLK_FREQ / 1_000_000 * DEBOUNCE_US;
  localparam int unsigned HOLD_CYCLES     = CLK_FREQ / 1000 * HOLD_MS;
  localparam int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Reject configurations the debounce window or button count cannot support.
  if (DEBOUNCE_CYCLES < 2 || NUM_BTN < 1 || NUM_BTN > 16 || HOLD_CYCLES < 1) begin : g_bad_cfg
    $error("button_conditioner: invalid parameter set");
  end

`ifdef BUTTON_CONDITIONER_LONG_PRESS_EN
  localparam int unsigned HOLD_W         = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESS_WAIT,
    S_PRESSED,
    S_RELEASE_WAIT
  } state_e;

  logic [NUM_BTN-1:0] btn_in;
  logic [NUM_BTN-1:0] sync1_q;
  logic [NUM_BTN-1:0] sync2_q;

  assign btn_in = ACTIVE_LOW ? ~btn_raw : btn_raw;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
    end
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             sync;

    assign sync = sync2_q[i];

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q   <= S_IDLE;
        cnt_q     <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
      end
    end

    // Any opposite sample during a wait state drops back and restarts the window.
    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      case (state_q)
        S_IDLE: begin
          if (sync) begin
            state_d = S_PRESS_WAIT;
            cnt_d   = CNT_W'(1);
          end
        end
        S_PRESS_WAIT: begin
          if (!sync) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = S_PRESSED;
            cnt_d   = '0;
            press_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_PRESSED: begin
          if (!sync) begin
            state_d = S_RELEASE_WAIT;
            cnt_d   = CNT_W'(1);
          end
        end
        S_RELEASE_WAIT: begin
          if (sync) begin
            state_d = S_PRESSED;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d   = S_IDLE;
            cnt_d     = '0;
            release_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
      level_d = (state_d == S_PRESSED) || (state_d == S_RELEASE_WAIT);
    end

    assign btn_level[i]   = level_q;
    assign btn_press[i]   = press_q;
    assign btn_release[i] = release_q;

`ifdef BUTTON_CONDITIONER_LONG_PRESS_EN
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              long_q, long_d;

    // Counts only while the press persists; the entry cycle and any release leave it at zero.
    always_comb begin
      hold_d = '0;
      long_d = 1'b0;
      if (level_q && level_d) begin
        if (hold_q == HOLD_MAX) begin
          hold_d = hold_q;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
          long_d = (hold_d == HOLD_MAX);
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        hold_q <= '0;
        long_q <= 1'b0;
      end else begin
        hold_q <= hold_d;
        long_q <= long_d;
      end
    end

    assign btn_long[i] = long_q;
`else
    assign btn_long[i] = 1'b0;
`endif
  end

endmodule
